// File: rtl/biquad_incremental_pipe.sv
// biquad_incremental_pipe: pipelined pole recursion y[k] = x[k] + A1*y[k-1] + A2*y[k-2] with saturating output
module biquad_incremental_pipe #(
    parameter int NBITS      = 16,
    parameter int NFRAC      = 2,
    parameter int NBITS2     = 24,
    parameter int NFRAC2     = 10,
    parameter int OUTBITS    = 12,
    parameter int OUTFRAC    = 0,
    parameter int NSAMP      = 8,
    parameter int COEFF_BITS = 18,
    parameter int COEFF_FRAC = 14,
    parameter     CLKTYPE    = "NONE"
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NBITS*NSAMP-1:0]       dat_i,
    input  logic                         dat_valid_i,
    input  logic [NBITS2-1:0]            y0_in,
    input  logic [NBITS2-1:0]            y1_in,
    input  logic                         bypass_i,
    input  logic                         coeff_adr_i,
    input  logic [COEFF_BITS-1:0]        coeff_dat_i,
    input  logic                         coeff_wr_i,
    input  logic                         coeff_update_i,
    input  logic                         sat_clr_i,
    output logic [OUTBITS*NSAMP-1:0]     dat_o,
    output logic                         dat_valid_o,
    output logic                         sat_o
);
    localparam int AW = NBITS2 + COEFF_BITS + 2;
    localparam int XS = NFRAC2 - NFRAC;
    localparam int QS = NFRAC2 - OUTFRAC;
    localparam int L  = NSAMP - 1;
    localparam logic signed [AW-1:0] YMAX = {{(AW-NBITS2+1){1'b0}}, {(NBITS2-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN = ~YMAX;
    localparam logic signed [AW-1:0] OMAX = {{(AW-OUTBITS+1){1'b0}}, {(OUTBITS-1){1'b1}}};
    localparam logic signed [AW-1:0] OMIN = ~OMAX;

    function automatic logic signed [NBITS2-1:0] pole(
        input logic signed [NBITS-1:0]      x,
        input logic signed [NBITS2-1:0]     y1,
        input logic signed [NBITS2-1:0]     y2,
        input logic signed [COEFF_BITS-1:0] c1,
        input logic signed [COEFF_BITS-1:0] c2
    );
        logic signed [AW-1:0] acc;
        acc = ((AW'(x) <<< (XS + COEFF_FRAC)) + AW'(y1) * AW'(c1) + AW'(y2) * AW'(c2)) >>> COEFF_FRAC;
        return (acc > YMAX) ? YMAX[NBITS2-1:0] : (acc < YMIN) ? YMIN[NBITS2-1:0] : acc[NBITS2-1:0];
    endfunction

    // Returns {clipped, sample} for a value held at NFRAC2 fractional bits
    function automatic logic [OUTBITS:0] quant(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] q;
        q = v >>> QS;
        return (q > OMAX) ? {1'b1, OMAX[OUTBITS-1:0]} : (q < OMIN) ? {1'b1, OMIN[OUTBITS-1:0]} : {1'b0, q[OUTBITS-1:0]};
    endfunction

    logic signed [COEFF_BITS-1:0] a1_sh, a2_sh, a1, a2;
    logic signed [COEFF_BITS-1:0] a1_p [NSAMP-2];
    logic signed [COEFF_BITS-1:0] a2_p [NSAMP-2];
    logic [NBITS*NSAMP-1:0]       x_p [NSAMP];
    logic [NBITS2*NSAMP-1:0]      y_p [NSAMP];
    logic                         v_p [NSAMP];
    logic                         b_p [NSAMP];
    logic [OUTBITS*NSAMP-1:0]     q_d;
    logic [NSAMP-1:0]             clip;

    // Shadow coefficient writes
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a1_sh <= '0;
            a2_sh <= '0;
        end else if (coeff_wr_i) begin
            if (coeff_adr_i) a1_sh <= coeff_dat_i;
            else             a2_sh <= coeff_dat_i;
        end

    if (CLKTYPE == "NONE") begin : g_coef
        // Active set takes the pre-write shadow on update
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                a1 <= '0;
                a2 <= '0;
            end else if (coeff_update_i) begin
                a1 <= a1_sh;
                a2 <= a2_sh;
            end
    end else begin : g_coef_xclk
        (* async_reg = "true" *) logic signed [COEFF_BITS-1:0] a1_r, a2_r;
        // Active set takes the pre-write shadow on update; tagged as crossing registers
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                a1_r <= '0;
                a2_r <= '0;
            end else if (coeff_update_i) begin
                a1_r <= a1_sh;
                a2_r <= a2_sh;
            end
        assign a1 = a1_r;
        assign a2 = a2_r;
    end

    // Capture frame, seeds, bypass flag and a snapshot of the active coefficients
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            x_p[0]  <= '0;
            y_p[0]  <= '0;
            v_p[0]  <= 1'b0;
            b_p[0]  <= 1'b0;
            a1_p[0] <= '0;
            a2_p[0] <= '0;
        end else begin
            x_p[0]  <= dat_i;
            y_p[0]  <= {{(NBITS2*(NSAMP-2)){1'b0}}, y1_in, y0_in};
            v_p[0]  <= dat_valid_i;
            b_p[0]  <= bypass_i;
            a1_p[0] <= a1;
            a2_p[0] <= a2;
        end

    for (genvar c = 1; c < NSAMP - 2; c++) begin : g_cf
        // Carry the frame's coefficient snapshot alongside it
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                a1_p[c] <= '0;
                a2_p[c] <= '0;
            end else begin
                a1_p[c] <= a1_p[c-1];
                a2_p[c] <= a2_p[c-1];
            end
    end

    for (genvar s = 1; s < NSAMP; s++) begin : g_st
        logic [NBITS2*NSAMP-1:0] y_nx;
        if (s + 1 < NSAMP) begin : g_calc
            // Fill in y[s+1] from y[s] and y[s-1] of the same frame
            always_comb begin
                y_nx = y_p[s-1];
                y_nx[NBITS2*(s+1) +: NBITS2] = pole($signed(x_p[s-1][NBITS*(s+1) +: NBITS]),
                    $signed(y_p[s-1][NBITS2*s +: NBITS2]), $signed(y_p[s-1][NBITS2*(s-1) +: NBITS2]),
                    a1_p[s-1], a2_p[s-1]);
            end
        end else begin : g_hold
            assign y_nx = y_p[s-1];
        end
        // Advance the frame one stage
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                x_p[s] <= '0;
                y_p[s] <= '0;
                v_p[s] <= 1'b0;
                b_p[s] <= 1'b0;
            end else begin
                x_p[s] <= x_p[s-1];
                y_p[s] <= y_nx;
                v_p[s] <= v_p[s-1];
                b_p[s] <= b_p[s-1];
            end
    end

    // Quantise the finished frame, or the raw samples when bypassed
    always_comb begin
        q_d  = '0;
        clip = '0;
        for (int k = 0; k < NSAMP; k++)
            {clip[k], q_d[OUTBITS*k +: OUTBITS]} = quant(b_p[L] ?
                (AW'($signed(x_p[L][NBITS*k +: NBITS])) <<< XS) : AW'($signed(y_p[L][NBITS2*k +: NBITS2])));
    end

    // Output register and sticky saturation flag (set beats clear)
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dat_o       <= '0;
            dat_valid_o <= 1'b0;
            sat_o       <= 1'b0;
        end else begin
            dat_o       <= q_d;
            dat_valid_o <= v_p[L];
            sat_o       <= (v_p[L] && |clip) ? 1'b1 : sat_clr_i ? 1'b0 : sat_o;
        end
endmodule
